// File: rtl/uart_apb_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-APB debug bridge.
package uart_apb_bridge_pkg;

    // Frame opcodes
    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

    // Response status bytes
    localparam logic [7:0] ST_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] ST_ERR = 8'h45;  // 'E'
    localparam logic [7:0] ST_BAD = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StWdata,
        StSetup,
        StAccess,
        StResp
    } state_e;

endpackage

// File: rtl/uart_apb_bridge.sv
// UART byte stream to APB requester bridge: parses W/R frames, runs one APB
// transfer per frame and streams the status (plus read data) back as bytes.
module uart_apb_bridge
    import uart_apb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [3:0]        pstrb,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic              rx_drop
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        last_q, last_d;
    logic [3:0]        hi_nib_q, hi_nib_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        status_q, status_d;

    logic   timed;
    logic   expired;
    state_e st_eff;

    // Next-state logic: frame parser, APB sequencing, response streaming and timeout
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        idx_d    = idx_q;
        last_d   = last_q;
        hi_nib_d = hi_nib_q;
        is_wr_d  = is_wr_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        rx_drop  = 1'b0;

        timed   = (state_q == StAddrHi) || (state_q == StAddrLo) || (state_q == StWdata);
        expired = timed && (cnt_q == CntMax);
        if (timed) begin
            cnt_d = rx_valid ? '0 : cnt_q + 1'b1;
        end
        // On expiry the frame is abandoned and a same-cycle byte starts a new one.
        st_eff  = expired ? StIdle : state_q;
        state_d = st_eff;

        unique case (st_eff)
            StIdle: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        is_wr_d = (rx_data == OP_WRITE);
                        state_d = StAddrHi;
                    end else begin
                        status_d = ST_BAD;
                        last_d   = 3'd0;
                        idx_d    = 3'd0;
                        state_d  = StResp;
                    end
                end
            end
            StAddrHi: begin
                if (rx_valid) begin
                    hi_nib_d = rx_data[3:0];
                    state_d  = StAddrLo;
                end
            end
            StAddrLo: begin
                if (rx_valid) begin
                    paddr_d = ADDR_W'({hi_nib_q, rx_data});
                    idx_d   = 3'd0;
                    state_d = is_wr_q ? StWdata : StSetup;
                end
            end
            StWdata: begin
                if (rx_valid) begin
                    // LSB arrives first, so shift in from the top.
                    pwdata_d = {rx_data, pwdata_q[31:8]};
                    idx_d    = idx_q + 3'd1;
                    if (idx_q == 3'd3) begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                rx_drop = rx_valid;
                state_d = StAccess;
            end
            StAccess: begin
                rx_drop = rx_valid;
                if (pready) begin
                    rdata_d  = prdata;
                    status_d = pslverr ? ST_ERR : ST_OK;
                    last_d   = is_wr_q ? 3'd0 : 3'd4;
                    idx_d    = 3'd0;
                    state_d  = StResp;
                end
            end
            StResp: begin
                rx_drop = rx_valid;
                if (tx_ready) begin
                    if (idx_q == last_q) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            last_q   <= 3'd0;
            hi_nib_q <= 4'd0;
            is_wr_q  <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
            status_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            hi_nib_q <= hi_nib_d;
            is_wr_q  <= is_wr_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    // Outputs decoded from registered state so reset clears APB control at once
    always_comb begin
        psel     = (state_q == StSetup) || (state_q == StAccess);
        penable  = (state_q == StAccess);
        pwrite   = is_wr_q;
        pstrb    = {4{is_wr_q}};
        paddr    = paddr_q;
        pwdata   = pwdata_q;
        busy     = (state_q != StIdle);
        tx_valid = (state_q == StResp);
        tx_data  = 8'd0;
        if (state_q == StResp) begin
            unique case (idx_q)
                3'd0:    tx_data = status_q;
                3'd1:    tx_data = rdata_q[7:0];
                3'd2:    tx_data = rdata_q[15:8];
                3'd3:    tx_data = rdata_q[23:16];
                default: tx_data = rdata_q[31:24];
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Self-checking bench for uart_apb_bridge: table of frames plus hand-written
// corner cases; response bytes are checked through an expected-byte queue.
module tb_uart_apb_bridge;

    localparam int unsigned T = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;
    logic        rx_drop;

    uart_apb_bridge #(.TIMEOUT_CYC(T), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .busy(busy), .rx_drop(rx_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  ahi;
        logic [7:0]  alo;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        err;
        logic [11:0] exp_paddr;
        logic        exp_pwrite;
        logic [3:0]  exp_pstrb;
        logic [7:0]  exp_status;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         drop_cnt = 0;
    int         psel_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count drops and APB selects, pop expected bytes on each handshake
    always @(negedge clk) begin
        if (rx_drop) drop_cnt++;
        if (psel) psel_cnt++;
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: got %h expected none", tx_data);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_psel();
        int n = 0;
        while (!psel && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check("idle_after", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit inject, input int stall);
        int en = 0;
        int d0;
        bit wr;
        wr = (v.op == 8'h57);
        tx_ready = (stall == 0);
        exp_q.push_back(v.exp_status);
        if (!wr) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(v.rdata[8*i +: 8]);
        end
        send_byte(v.op);
        send_byte(v.ahi);
        send_byte(v.alo);
        if (wr) begin
            for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8]);
        end
        wait_psel();
        check("setup_psel", 32'(psel), 32'd1);
        check("setup_penable", 32'(penable), 32'd0);
        check("paddr", 32'(paddr), 32'(v.exp_paddr));
        check("pwrite", 32'(pwrite), 32'(v.exp_pwrite));
        check("pstrb", 32'(pstrb), 32'(v.exp_pstrb));
        if (wr) check("pwdata", pwdata, v.wdata);
        tick();
        d0 = drop_cnt;
        for (int i = 0; i < v.waits; i++) begin
            if (penable) en++;
            if (inject && i == 0) begin
                rx_data  = 8'h57;
                rx_valid = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
            check("paddr_hold", 32'(paddr), 32'(v.exp_paddr));
        end
        prdata  = v.rdata;
        pslverr = v.err;
        pready  = 1'b1;
        if (penable) en++;
        tick();
        pready  = 1'b0;
        prdata  = 32'd0;
        pslverr = 1'b0;
        check("penable_cycles", 32'(en), 32'(v.waits + 1));
        check("psel_after", 32'(psel), 32'd0);
        check("tx_valid_rise", 32'(tx_valid), 32'd1);
        for (int i = 0; i < stall; i++) begin
            check("tx_hold_data", 32'(tx_data), 32'(v.exp_status));
            tick();
        end
        tx_ready = 1'b1;
        wait_idle();
        if (inject) check("rx_drop_pulses", 32'(drop_cnt - d0), 32'd1);
    endtask

    initial begin
        int p0;
        vecs[0] = '{8'h57, 8'h0F, 8'hFC, 32'h12345678, 0, 32'h0, 1'b0,
                    12'hFFC, 1'b1, 4'hF, 8'h4B};
        vecs[1] = '{8'h52, 8'h00, 8'h0C, 32'h0, 3, 32'hA5A5_0001, 1'b0,
                    12'h00C, 1'b0, 4'h0, 8'h4B};
        vecs[2] = '{8'h52, 8'h01, 8'h20, 32'h0, 1, 32'hDEADBEEF, 1'b1,
                    12'h120, 1'b0, 4'h0, 8'h45};
        vecs[3] = '{8'h57, 8'hF3, 8'h40, 32'hCAFEF00D, 2, 32'h0, 1'b1,
                    12'h340, 1'b1, 4'hF, 8'h45};

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h0; tx_ready = 1'b1;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        tick();
        tick();
        check("rst_state", {psel, penable, pwrite, pstrb, tx_valid, busy, rx_drop},
              32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0, 0);

        // Response held off by tx_ready, and a byte dropped during ACCESS
        run_vec(vecs[1], 1'b0, 10);
        run_vec(vecs[1], 1'b1, 0);

        // Bad opcode: single '?' reply, no APB traffic
        p0 = psel_cnt;
        exp_q.push_back(8'h3F);
        send_byte(8'h41);
        check("bad_busy", 32'(busy), 32'd1);
        wait_idle();
        check("bad_no_apb", 32'(psel_cnt - p0), 32'd0);

        // Partial frame times out with no transfer and no response
        p0 = psel_cnt;
        send_byte(8'h57);
        send_byte(8'h00);
        for (int i = 0; i < int'(T) - 1; i++) tick();
        check("to_still_busy", 32'(busy), 32'd1);
        tick();
        check("to_idle", 32'(busy), 32'd0);
        check("to_no_tx", 32'(tx_valid), 32'd0);
        check("to_no_apb", 32'(psel_cnt - p0), 32'd0);
        run_vec(vecs[0], 1'b0, 0);

        // Reset in ACCESS drops APB control asynchronously, no reply follows
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h10);
        for (int i = 0; i < 4; i++) send_byte(8'h11);
        wait_psel();
        tick();
        check("pre_rst_penable", 32'(penable), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_psel", 32'(psel), 32'd0);
        check("async_penable", 32'(penable), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_outs", {pwrite, pstrb, tx_valid, rx_drop, tx_data}, 32'd0);
        check("async_paddr", 32'(paddr), 32'd0);
        check("async_pwdata", pwdata, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_tx", 32'(tx_valid), 32'd0);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);
        run_vec(vecs[2], 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
